// File: rtl/game_pkg.sv
// Shared types and default timing constants for the song play-session sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAYING   = 3'd2,
        PAUSED    = 3'd3,
        RESULT    = 3'd4
    } state_t;

    localparam int SONG_FRAMES_DEF      = 5680;
    localparam int COUNTDOWN_FRAMES_DEF = 180;
    localparam int RESULT_FRAMES_DEF    = 600;
    localparam int TIME_W               = 16;

endpackage

// File: rtl/game_flow_ctrl_rise_edge.sv
// Rising-edge detector; RST_VAL picks the history value so a level held through reset can be masked.
module rise_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (!reset) prev_reg <= RST_VAL;
        else        prev_reg <= in;
    end

    assign pulse = in & ~prev_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// Song play-session sequencer: countdown, playing, pause, result screen, with the play-time frame counter.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int SONG_FRAMES      = SONG_FRAMES_DEF,
    parameter int COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEF,
    parameter int RESULT_FRAMES    = RESULT_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_frame,
    input  logic              start_key,
    input  logic              pause_key,
    input  logic              abort_key,
    output logic [2:0]        state_o,
    output logic [TIME_W-1:0] play_time,
    output logic [7:0]        cd_frames,
    output logic              audio_en,
    output logic              logic_en,
    output logic              frame_tick,
    output logic              score_clr,
    output logic              song_done
);

    localparam logic [TIME_W-1:0] SONG_END  = TIME_W'(SONG_FRAMES);
    localparam logic [TIME_W-1:0] SONG_LAST = TIME_W'(SONG_FRAMES - 1);
    localparam logic [TIME_W-1:0] RES_LAST  = TIME_W'(RESULT_FRAMES - 1);
    localparam logic [7:0]        CD_INIT   = 8'(COUNTDOWN_FRAMES);

    logic [3:0] raw;
    logic [3:0] edges;
    logic frame_edge, start_edge, pause_edge, abort_edge;

    assign raw = {abort_key, pause_key, start_key, new_frame};

    // Bit 0 is the frame strobe (history resets low); the keys reset high so held keys do not fire.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            rise_edge #(.RST_VAL((gi == 0) ? 1'b0 : 1'b1)) u_edge (
                .clk   (clk),
                .reset (reset),
                .in    (raw[gi]),
                .pulse (edges[gi])
            );
        end
    endgenerate

    assign frame_edge = edges[0];
    assign start_edge = edges[1];
    assign pause_edge = edges[2];
    assign abort_edge = edges[3];

    state_t            state_reg, state_next;
    logic [TIME_W-1:0] play_time_reg, play_time_next;
    logic [7:0]        cd_reg, cd_next;
    logic [TIME_W-1:0] res_reg, res_next;
    logic              tick_reg, tick_next;
    logic              clr_reg, clr_next;
    logic              done_reg, done_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            play_time_reg <= '0;
            cd_reg        <= '0;
            res_reg       <= '0;
            tick_reg      <= 1'b0;
            clr_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            play_time_reg <= play_time_next;
            cd_reg        <= cd_next;
            res_reg       <= res_next;
            tick_reg      <= tick_next;
            clr_reg       <= clr_next;
            done_reg      <= done_next;
        end
    end

    // Events ignored in a state do not block lower-priority events that are acted on.
    always_comb begin
        state_next     = state_reg;
        play_time_next = play_time_reg;
        cd_next        = cd_reg;
        res_next       = res_reg;
        tick_next      = 1'b0;
        clr_next       = 1'b0;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next     = COUNTDOWN;
                    cd_next        = CD_INIT;
                    play_time_next = '0;
                    clr_next       = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (abort_edge) begin
                    state_next = IDLE;
                    cd_next    = '0;
                end else if (frame_edge) begin
                    if (cd_reg <= 8'd1) begin
                        cd_next    = '0;
                        state_next = PLAYING;
                    end else begin
                        cd_next = cd_reg - 8'd1;
                    end
                end
            end
            PLAYING: begin
                if (abort_edge) begin
                    state_next     = IDLE;
                    play_time_next = '0;
                end else if (pause_edge) begin
                    state_next = PAUSED;
                end else if (frame_edge) begin
                    tick_next = 1'b1;
                    if (play_time_reg >= SONG_LAST) begin
                        play_time_next = SONG_END;
                        state_next     = RESULT;
                        done_next      = 1'b1;
                        res_next       = '0;
                    end else begin
                        play_time_next = play_time_reg + 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (abort_edge) begin
                    state_next     = IDLE;
                    play_time_next = '0;
                end else if (pause_edge) begin
                    state_next = PLAYING;
                end
            end
            RESULT: begin
                if (abort_edge || start_edge) begin
                    state_next     = IDLE;
                    play_time_next = '0;
                end else if (frame_edge) begin
                    if (res_reg >= RES_LAST) begin
                        state_next     = IDLE;
                        play_time_next = '0;
                        res_next       = RES_LAST + 1'b1;
                    end else begin
                        res_next = res_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_o    = state_reg;
    assign play_time  = play_time_reg;
    assign cd_frames  = cd_reg;
    assign audio_en   = (state_reg == PLAYING);
    assign logic_en   = (state_reg == PLAYING);
    assign frame_tick = tick_reg;
    assign score_clr  = clr_reg;
    assign song_done  = done_reg;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level sequencer for one song play session.
- Turns key presses and the per-frame strobe into session states: idle, countdown, playing, paused, result.
- Owns the authoritative play-time frame counter, with pause support.
- Gates audio playback and note/score logic, and issues the score-clear and song-done pulses consumed by the rest of the game datapath.

Parameters:
- SONG_FRAMES, 5680: song length in frames; play_time terminal count.
- COUNTDOWN_FRAMES, 180: pre-song countdown length in frames (3 s at 60 Hz).
- RESULT_FRAMES, 600: frames the result screen is held before auto-return to idle.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- new_frame  in  1  frame strobe level (vsync-derived, already in clk domain); rising edge = one frame.
- start_key  in  1  start/confirm key level.
- pause_key  in  1  pause/resume toggle key level.
- abort_key  in  1  quit-to-idle key level.
- state_o  out  3  current state encoding (game_pkg enum).
- play_time  out  16  frames elapsed in song.
- cd_frames  out  8  countdown frames remaining.
- audio_en  out  1  high only in PLAYING.
- logic_en  out  1  high only in PLAYING.
- frame_tick  out  1  1-cycle pulse per counted play frame.
- score_clr  out  1  1-cycle pulse on entry to COUNTDOWN.
- song_done  out  1  1-cycle pulse on entry to RESULT.

Behaviour:
Edge detection and reset
- Each input has a rising-edge detector: edge = in & ~prev, where prev is registered.
- new_frame prev resets to 0. Key prev registers reset to 1, so a key held through reset does not fire.
- Edges are combinational from the current input; the state effect is visible after the next clk edge (1-cycle latency).
- While reset==0 at a clk edge: state=IDLE, play_time=0, cd_frames=0, result counter=0, all pulses 0, audio_en=logic_en=0.

Priority and pulses
- Within a cycle: abort > pause > start > frame.
- Pulses are registered, high exactly one cycle, concurrent with the state change that causes them.

IDLE
- start edge -> COUNTDOWN; cd_frames <= COUNTDOWN_FRAMES; play_time <= 0; score_clr pulse.
- pause and abort edges are ignored.

COUNTDOWN
- abort -> IDLE, cd_frames <= 0.
- Frame edge: cd_frames decrements. If cd_frames==1, also -> PLAYING (cd_frames becomes 0).
- pause and start edges are ignored.

PLAYING
- abort -> IDLE, play_time <= 0.
- pause edge -> PAUSED. A frame edge in the same cycle is dropped.
- Frame edge: play_time+1 and frame_tick pulse.
- If play_time==SONG_FRAMES-1 on a frame edge: play_time <= SONG_FRAMES, -> RESULT, song_done pulse (frame_tick also pulses).

PAUSED
- play_time is held and frame edges are ignored.
- pause edge -> PLAYING.
- abort -> IDLE, play_time <= 0.

RESULT
- play_time is held at SONG_FRAMES.
- The result counter counts frame edges, starting from 0 on entry.
- start edge, abort edge, or result counter reaching RESULT_FRAMES -> IDLE, play_time <= 0.

Arithmetic and outputs
- All counters are unsigned and saturate; none wrap. play_time never exceeds SONG_FRAMES.
- audio_en and logic_en are decoded from the registered state.
- Reset asserted mid-operation in any state returns to IDLE on the next clk edge, with all reset values as above.

Decomposition:
- Package game_pkg:
  - state enum: IDLE, COUNTDOWN, PLAYING, PAUSED, RESULT.
  - default constants: SONG_FRAMES_DEF=5680, COUNTDOWN_FRAMES_DEF=180, RESULT_FRAMES_DEF=600.
  - TIME_W=16.
- Sub-module rise_edge:
  - parameter RST_VAL sets prev's reset value.
  - inputs clk, reset, in; output pulse.
  - instantiated 4×.

Test Plan (SONG_FRAMES=10, COUNTDOWN_FRAMES=3, RESULT_FRAMES=4):
- Reset with start_key held high, then release reset -> state IDLE, no score_clr. Release and re-press start -> COUNTDOWN, cd_frames=3, score_clr single pulse.
- 3 new_frame edges in COUNTDOWN -> cd_frames 2,1,0, then PLAYING. audio_en=1 on the clk after the 3rd edge; play_time=0.
- 10 frame edges in PLAYING -> 10 frame_tick pulses, play_time 1..10, state RESULT. song_done pulses once on the same cycle as the 10th tick; audio_en=0.
- Pause after play_time=4, give 5 frame edges, resume, give 1 frame -> play_time stays 4 while PAUSED, then 5. Pause and frame in the same cycle -> PAUSED, play_time=4, no frame_tick.
- abort in PAUSED at play_time=7 -> IDLE, play_time=0, no song_done. In RESULT, 4 frame edges -> IDLE, play_time=0.
- Drive reset low mid-PLAYING at play_time=6 -> next clk: IDLE, play_time=0, all outputs 0.
